// File: rtl/gfx_pkg.sv
// rtl/gfx_pkg.sv - shared graphics types for the depth-test stage
// Contents:
//   FRAG_DW/FRAG_CW/FRAG_AW  default depth/colour/address widths (160x120 screen)
//   DEPTH_FAR                farthest depth value (all ones) at the default width
//   fragment_t               rasterizer fragment {addr, depth, color}
//   depth_state_t            depth-test control states {CLEAR, RUN, DRAIN}
package gfx_pkg;

    localparam int FRAG_DW = 12;
    localparam int FRAG_CW = 4;
    localparam int FRAG_AW = $clog2(160 * 120);

    localparam logic [FRAG_DW-1:0] DEPTH_FAR = {FRAG_DW{1'b1}};

    typedef struct packed {
        logic [FRAG_AW-1:0] addr;
        logic [FRAG_DW-1:0] depth;
        logic [FRAG_CW-1:0] color;
    } fragment_t;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } depth_state_t;

endpackage

// File: rtl/depth_test.sv
// rtl/depth_test.sv - pipelined z-buffer stage with frame-clear sweep
// Ports:
//   clk, rstn                  clock, asynchronous active-low reset
//   i_clear                    frame clear request (taken in RUN only)
//   o_ready                    fragment accepted this cycle when high
//   i_frag_*                   incoming fragment (valid, addr, depth, color)
//   o_db_raddr / i_db_rdata    depth-buffer read port (1-cycle, read-first)
//   o_db_* / o_fb_*            depth-buffer / framebuffer write ports
//   o_clear_done               one-cycle pulse when the sweep completes
//   o_pass_count/o_fail_count  depth-test statistics
// Optional feature: define DEPTH_TEST_STATS_EN to build the saturating
// pass/fail counters; otherwise both count ports are tied to zero.
module depth_test #(
    parameter int DATAWIDTH     = 12,
    parameter int COLORWIDTH    = 4,
    parameter int SCREEN_WIDTH  = 160,
    parameter int SCREEN_HEIGHT = 120,
    parameter int ADDRWIDTH     = $clog2(SCREEN_WIDTH * SCREEN_HEIGHT),
    parameter logic [COLORWIDTH-1:0] BG_INDEX = '0
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  i_clear,
    output logic                  o_ready,
    input  logic                  i_frag_valid,
    input  logic [ADDRWIDTH-1:0]  i_frag_addr,
    input  logic [DATAWIDTH-1:0]  i_frag_depth,
    input  logic [COLORWIDTH-1:0] i_frag_color,
    output logic [ADDRWIDTH-1:0]  o_db_raddr,
    input  logic [DATAWIDTH-1:0]  i_db_rdata,
    output logic                  o_db_we,
    output logic [ADDRWIDTH-1:0]  o_db_waddr,
    output logic [DATAWIDTH-1:0]  o_db_wdata,
    output logic                  o_fb_we,
    output logic [ADDRWIDTH-1:0]  o_fb_waddr,
    output logic [COLORWIDTH-1:0] o_fb_wdata,
    output logic                  o_clear_done,
    output logic [15:0]           o_pass_count,
    output logic [15:0]           o_fail_count
);

    import gfx_pkg::*;

    localparam logic [ADDRWIDTH-1:0] LAST_ADDR = ADDRWIDTH'(SCREEN_WIDTH * SCREEN_HEIGHT - 1);

    depth_state_t           state_q;
    logic [ADDRWIDTH-1:0]   cnt_q;
    logic                   sweep_end_q;

    // S1: fragment waiting for its stored depth
    logic                   s1_valid_q;
    logic [ADDRWIDTH-1:0]   s1_addr_q;
    logic [DATAWIDTH-1:0]   s1_depth_q;
    logic [COLORWIDTH-1:0]  s1_color_q;

    // Write port registers, shared by the sweep and the pipeline
    logic                   we_q;
    logic [ADDRWIDTH-1:0]   waddr_q;
    logic [DATAWIDTH-1:0]   db_wdata_q;
    logic [COLORWIDTH-1:0]  fb_wdata_q;

    // Copy of last cycle's depth write, still invisible to the read-first RAM
    logic                   prev_we_q;
    logic [ADDRWIDTH-1:0]   prev_addr_q;
    logic [DATAWIDTH-1:0]   prev_depth_q;

    logic                   clear_done_q;

    logic                   accept_d;
    logic [DATAWIDTH-1:0]   stored_depth_d;
    logic                   pass_d;

    assign o_ready    = (state_q == RUN);
    assign accept_d   = (state_q == RUN) && i_frag_valid;
    assign o_db_raddr = i_frag_addr;

    // The RAM read for S1 was issued before the two most recent writes
    // committed, so those writes are forwarded; the current one is newest.
    always_comb begin
        stored_depth_d = i_db_rdata;
        if (prev_we_q && (prev_addr_q == s1_addr_q)) begin
            stored_depth_d = prev_depth_q;
        end
        if (we_q && (waddr_q == s1_addr_q)) begin
            stored_depth_d = db_wdata_q;
        end
        pass_d = s1_valid_q && (s1_depth_q < stored_depth_d);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= CLEAR;
            cnt_q        <= '0;
            sweep_end_q  <= 1'b0;
            s1_valid_q   <= 1'b0;
            s1_addr_q    <= '0;
            s1_depth_q   <= '0;
            s1_color_q   <= '0;
            we_q         <= 1'b0;
            waddr_q      <= '0;
            db_wdata_q   <= '0;
            fb_wdata_q   <= '0;
            prev_we_q    <= 1'b0;
            prev_addr_q  <= '0;
            prev_depth_q <= '0;
            clear_done_q <= 1'b0;
        end else begin
            prev_we_q    <= we_q;
            prev_addr_q  <= waddr_q;
            prev_depth_q <= db_wdata_q;
            we_q         <= 1'b0;
            clear_done_q <= 1'b0;
            s1_valid_q   <= accept_d;
            if (accept_d) begin
                s1_addr_q  <= i_frag_addr;
                s1_depth_q <= i_frag_depth;
                s1_color_q <= i_frag_color;
            end
            case (state_q)
                CLEAR: begin
                    if (!sweep_end_q) begin
                        we_q       <= 1'b1;
                        waddr_q    <= cnt_q;
                        db_wdata_q <= '1;
                        fb_wdata_q <= BG_INDEX;
                        if (cnt_q == LAST_ADDR) begin
                            sweep_end_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + ADDRWIDTH'(1);
                        end
                    end else begin
                        // Cycle after the last sweep write
                        sweep_end_q  <= 1'b0;
                        cnt_q        <= '0;
                        clear_done_q <= 1'b1;
                        state_q      <= RUN;
                    end
                end
                RUN, DRAIN: begin
                    if (pass_d) begin
                        we_q       <= 1'b1;
                        waddr_q    <= s1_addr_q;
                        db_wdata_q <= s1_depth_q;
                        fb_wdata_q <= s1_color_q;
                    end
                    if (state_q == RUN) begin
                        if (i_clear) begin
                            state_q <= DRAIN;
                        end
                    end else if (!s1_valid_q) begin
                        // Last fragment's write is already registered and
                        // commits on this edge, ahead of the sweep.
                        state_q     <= CLEAR;
                        cnt_q       <= '0;
                        sweep_end_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= CLEAR;
                end
            endcase
        end
    end

`ifdef DEPTH_TEST_STATS_EN
    logic [15:0] pass_cnt_q;
    logic [15:0] fail_cnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
        end else if ((state_q == DRAIN) && !s1_valid_q) begin
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
        end else if (s1_valid_q) begin
            if (pass_d) begin
                if (pass_cnt_q != 16'hFFFF) pass_cnt_q <= pass_cnt_q + 16'd1;
            end else begin
                if (fail_cnt_q != 16'hFFFF) fail_cnt_q <= fail_cnt_q + 16'd1;
            end
        end
    end

    assign o_pass_count = pass_cnt_q;
    assign o_fail_count = fail_cnt_q;
`else
    assign o_pass_count = '0;
    assign o_fail_count = '0;
`endif

    assign o_db_we      = we_q;
    assign o_fb_we      = we_q;
    assign o_db_waddr   = waddr_q;
    assign o_fb_waddr   = waddr_q;
    assign o_db_wdata   = db_wdata_q;
    assign o_fb_wdata   = fb_wdata_q;
    assign o_clear_done = clear_done_q;

endmodule

// File: tb/tb_depth_test.sv
// tb/tb_depth_test.sv - scoreboard testbench for depth_test
module tb_depth_test;

`ifdef DEPTH_TEST_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    localparam int NPIX = 19200;

    typedef struct packed {
        logic [14:0] addr;
        logic [11:0] depth;
        logic [3:0]  color;
    } wr_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        i_clear = 1'b0;
    logic        o_ready;
    logic        i_frag_valid = 1'b0;
    logic [14:0] i_frag_addr = '0;
    logic [11:0] i_frag_depth = '0;
    logic [3:0]  i_frag_color = '0;
    logic [14:0] o_db_raddr;
    logic [11:0] i_db_rdata = '0;
    logic        o_db_we;
    logic [14:0] o_db_waddr;
    logic [11:0] o_db_wdata;
    logic        o_fb_we;
    logic [14:0] o_fb_waddr;
    logic [3:0]  o_fb_wdata;
    logic        o_clear_done;
    logic [15:0] o_pass_count;
    logic [15:0] o_fail_count;

    logic [11:0] db_mem [0:32767];
    logic [3:0]  fb_mem [0:32767];

    wr_t exp_q[$];
    wr_t mon_e;
    int  checks = 0;
    int  failures = 0;
    int  pass_model = 0;
    int  fail_model = 0;

    depth_test dut (
        .clk(clk), .rstn(rstn), .i_clear(i_clear), .o_ready(o_ready),
        .i_frag_valid(i_frag_valid), .i_frag_addr(i_frag_addr),
        .i_frag_depth(i_frag_depth), .i_frag_color(i_frag_color),
        .o_db_raddr(o_db_raddr), .i_db_rdata(i_db_rdata),
        .o_db_we(o_db_we), .o_db_waddr(o_db_waddr), .o_db_wdata(o_db_wdata),
        .o_fb_we(o_fb_we), .o_fb_waddr(o_fb_waddr), .o_fb_wdata(o_fb_wdata),
        .o_clear_done(o_clear_done), .o_pass_count(o_pass_count),
        .o_fail_count(o_fail_count)
    );

    always #5 clk = ~clk;

    // Depth buffer and framebuffer: 1-cycle read latency, read-first
    always @(posedge clk) begin
        i_db_rdata <= db_mem[o_db_raddr];
        if (o_db_we) db_mem[o_db_waddr] <= o_db_wdata;
        if (o_fb_we) fb_mem[o_fb_waddr] <= o_fb_wdata;
    end

    // Monitor: every write cycle must match the next expected write
    always @(negedge clk) begin
        if (rstn && (o_db_we || o_fb_we)) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL write_unexpected: got addr=%0d depth=%0h color=%0h, none expected",
                         o_db_waddr, o_db_wdata, o_fb_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                if (!(o_db_we && o_fb_we && o_db_waddr == mon_e.addr && o_fb_waddr == mon_e.addr &&
                      o_db_wdata == mon_e.depth && o_fb_wdata == mon_e.color)) begin
                    failures++;
                    $display("FAIL write_match: got we=%b/%b addr=%0d/%0d depth=%0h color=%0h expected addr=%0d depth=%0h color=%0h",
                             o_db_we, o_fb_we, o_db_waddr, o_fb_waddr, o_db_wdata, o_fb_wdata,
                             mon_e.addr, mon_e.depth, mon_e.color);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_sweep();
        for (int i = 0; i < NPIX; i++) exp_q.push_back(wr_t'{addr: 15'(i), depth: 12'hFFF, color: 4'h0});
    endtask

    task automatic frag(input int addr, input int depth, input int color, input bit exp_pass);
        i_frag_valid = 1'b1;
        i_frag_addr  = 15'(addr);
        i_frag_depth = 12'(depth);
        i_frag_color = 4'(color);
        if (exp_pass) begin
            exp_q.push_back(wr_t'{addr: 15'(addr), depth: 12'(depth), color: 4'(color)});
            pass_model++;
        end else begin
            fail_model++;
        end
        #1;
        check("ready_at_issue", {31'd0, o_ready}, 32'd1);
        check("raddr_comb", {17'd0, o_db_raddr}, addr);
        @(posedge clk);
        #1;
        i_frag_valid = 1'b0;
        i_frag_addr  = '0;
    endtask

    task automatic check_counts(input string name);
        check({name, "_pass"}, {16'd0, o_pass_count}, STATS ? pass_model : 0);
        check({name, "_fail"}, {16'd0, o_fail_count}, STATS ? fail_model : 0);
    endtask

    // Returns the number of cycles until o_clear_done, counting write cycles
    task automatic wait_done(output int n, output int we_cycles, output bit ready_seen);
        n = 0;
        we_cycles = 0;
        ready_seen = 1'b0;
        while (!o_clear_done && n < 30000) begin
            if (o_db_we && o_fb_we) we_cycles++;
            if (o_ready) ready_seen = 1'b1;
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    initial begin
        int n;
        int wc;
        bit rs;

        idle(3);
        check("rst_ready", {31'd0, o_ready}, 0);
        check("rst_db_we", {31'd0, o_db_we}, 0);
        check("rst_fb_we", {31'd0, o_fb_we}, 0);
        check("rst_clear_done", {31'd0, o_clear_done}, 0);
        check("rst_counts", {o_pass_count, o_fail_count}, 0);

        // Reset sweep: addresses 0..19199, done on cycle 19200
        push_sweep();
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        wait_done(n, wc, rs);
        check("sweep_cycles", n, NPIX);
        check("sweep_we_cycles", wc, NPIX);
        check("sweep_ready_early", {31'd0, rs}, 0);
        check("sweep_ready_at_done", {31'd0, o_ready}, 1);
        check("sweep_queue_empty", exp_q.size(), 0);
        idle(1);
        check("clear_done_pulse", {31'd0, o_clear_done}, 0);

        // Single fragment, two-cycle write latency
        frag(100, 'h800, 5, 1'b1);
        check("lat_n1_we", {31'd0, o_db_we}, 0);
        idle(1);
        check("lat_n2_we", {31'd0, o_db_we}, 1);
        check("lat_n2_addr", {17'd0, o_db_waddr}, 100);
        idle(3);
        check_counts("single");

        // Back-to-back same address: forwarding from the current write
        frag(50, 'h800, 1, 1'b1);
        frag(50, 'h900, 2, 1'b0);
        idle(4);
        check("b2b_mem50", {20'd0, db_mem[50]}, 'h800);
        check_counts("b2b");

        // One-apart same address: forwarding from the previous write
        frag(60, 'h800, 3, 1'b1);
        frag(7,  'h100, 4, 1'b1);
        frag(60, 'h700, 6, 1'b1);
        frag(61, 'h800, 7, 1'b1);
        frag(8,  'h100, 8, 1'b1);
        frag(61, 'h900, 9, 1'b0);
        idle(4);
        check("gap_mem60", {20'd0, db_mem[60]}, 'h700);
        check("gap_fb60", {28'd0, fb_mem[60]}, 6);
        check("gap_mem61", {20'd0, db_mem[61]}, 'h800);
        check_counts("gap");

        // Equal depth fails, both forwarded and from memory
        frag(9, 'h400, 10, 1'b1);
        frag(9, 'h400, 11, 1'b0);
        idle(2);
        frag(9, 'h400, 12, 1'b0);
        frag(9, 'h3FF, 13, 1'b1);
        idle(4);
        check("eq_mem9", {20'd0, db_mem[9]}, 'h3FF);
        check("eq_fb9", {28'd0, fb_mem[9]}, 13);
        check_counts("equal");

        // Clear with two fragments in flight
        frag(200, 'h300, 1, 1'b1);
        frag(201, 'h300, 2, 1'b1);
        i_clear = 1'b1;
        check("clear_req_ready", {31'd0, o_ready}, 1);
        @(posedge clk);
        #1;
        i_clear = 1'b0;
        push_sweep();
        pass_model = 0;
        fail_model = 0;
        check("drain_ready", {31'd0, o_ready}, 0);
        idle(2);
        check_counts("clear_entry");
        wait_done(n, wc, rs);
        check("clear2_done_seen", {31'd0, o_clear_done}, 1);
        check("clear2_ready_early", {31'd0, rs}, 0);
        check("clear2_queue_empty", exp_q.size(), 0);
        check("clear2_mem200", {20'd0, db_mem[200]}, 'hFFF);

        // Near-far boundary after a fresh clear
        frag(200, 'hFFF, 1, 1'b0);
        frag(201, 'hFFE, 2, 1'b1);
        idle(4);
        check("far_mem201", {20'd0, db_mem[201]}, 'hFFE);
        check_counts("far");
        check("final_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
